eth_rx_demux: RTL and testbench
===============================

Name: eth_rx_demux

Overview:
- Byte-wide Ethernet receive demultiplexer between MAC RX AXI-Stream and the protocol engines (ARP, IPv4, and future protocols).
- Parses the 14-byte L2 header and filters on destination MAC.
- Strips the header and routes the payload to one of NUM_CH output streams, selected by a parametrised EtherType table.
- Honours per-channel backpressure, aborts stalled frames on timeout, and keeps saturating forward/drop counters.

Parameters:
- NUM_CH, 2, number of output channels (1..8)
- ETHERTYPES, {16'h0800,16'h0806}, NUM_CH*16-bit table; channel i matches slice [16i+15:16i] (default: ch0 = ARP, ch1 = IPv4)
- TIMEOUT_CYCLES, 4096, idle cycles mid-frame before abort
- CNT_WIDTH, 16, width of statistics counters

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- local_mac  in  48  station MAC address
- promisc  in  1  accept any destination MAC
- s_axis_tdata  in  8  RX byte
- s_axis_tvalid  in  1  RX valid
- s_axis_tlast  in  1  RX last byte of frame
- s_axis_tready  out  1  RX ready
- m_axis_tdata  out  NUM_CH*8  payload bytes, channel i at [8i+7:8i]
- m_axis_tvalid  out  NUM_CH  per-channel valid
- m_axis_tlast  out  NUM_CH  per-channel last
- m_axis_tuser  out  NUM_CH  per-channel abort flag, valid with tlast
- m_axis_tready  in  NUM_CH  per-channel ready
- fwd_cnt  out  CNT_WIDTH  frames forwarded, saturating
- drop_cnt  out  CNT_WIDTH  frames dropped or aborted, saturating

Behaviour:
- Reset: state=HDR, byte_cnt=0, timer=0, all m_axis_* = 0, counters = 0, s_axis_tready = 1. Reset mid-frame discards the frame without an abort beat; the next byte is treated as byte 0 of a new frame.
- Beat = s_axis_tvalid && s_axis_tready.

States:
- HDR
  - tready = 1.
  - byte_cnt (4 bits) counts beats 0..13.
  - Bytes 0-5 are compared incrementally against local_mac (MSB first) and against FF; a sticky mac_ok is kept.
  - Bytes 12-13 form the EtherType.
  - On the beat of byte 13, the lowest channel index whose table entry equals the EtherType is selected.
  - Go to FWD if (mac_ok || broadcast || promisc) && match && !tlast; otherwise go to DROP.
  - A tlast on any byte <= 13 is a runt: increment drop_cnt and stay in HDR with byte_cnt = 0.
- FWD
  - s_axis_tready = skid in_ready of the selected channel; beats are pushed into that channel's skid, with tuser = 0.
  - On a tlast beat: increment fwd_cnt, go to HDR.
  - Unselected channels see no traffic.
- DROP
  - tready = 1; beats are consumed.
  - On tlast: increment drop_cnt, go to HDR.
- ABORT
  - tready = 0.
  - Push one beat to the selected channel: tdata = 0, tlast = 1, tuser = 1.
  - When the skid accepts it: increment drop_cnt, go to HDR.

Timer:
- Counts cycles with s_axis_tvalid = 0 while in-frame (FWD, DROP, or HDR with byte_cnt != 0).
- Cleared on every beat and on a state change to HDR.
- Downstream backpressure never advances the timer.
- On reaching TIMEOUT_CYCLES-1:
  - from FWD: go to ABORT;
  - from HDR or DROP: increment drop_cnt, go to HDR with byte_cnt = 0.
- A beat arriving in the same cycle as expiry wins: it is accepted and the timer clears.

Latency and throughput:
- Latency is 1 cycle from an accepted beat to m_axis_tvalid.
- Full throughput of 1 byte/clk.
- The header adds 14 idle output cycles.

Counters:
- Saturate at all-ones.
- Simultaneous increment sources are impossible by construction; this is asserted in simulation.

Decomposition:
- Package eth_pkg: ETH_HDR_LEN = 14, ETHTYPE_IPV4 = 16'h0800, ETHTYPE_ARP = 16'h0806, MAC_BCAST, and a state enum (HDR, FWD, DROP, ABORT).
- Sub-module axis_skid_buf: a 2-entry, 10-bit (data+last+user) register slice with registered ready, instantiated NUM_CH times via generate.

Test Plan:
- IPv4 frame (dst = local_mac, type 0800, 46 payload bytes 0x00..0x2D) -> ch1 emits exactly 46 bytes 0x00..0x2D, tlast on 0x2D, tuser = 0; ch0 idle; fwd_cnt = 1.
- ARP broadcast (dst FF:FF:FF:FF:FF:FF, type 0806, 28 bytes) -> ch0 emits 28 bytes; then type 86DD frame -> no output, drop_cnt = 1; wrong dst with promisc = 0 -> dropped, drop_cnt = 2; same frame with promisc = 1 -> forwarded.
- Backpressure: m_axis_tready[1] toggled 1/0 every cycle during a 64-byte IPv4 payload -> all 64 bytes delivered in order with no loss or duplication; s_axis_tready low only while the skid is full.
- Runt: 10-byte frame with tlast on byte 9 -> drop_cnt += 1; an immediately following valid ARP frame is forwarded correctly.
- Timeout: TIMEOUT_CYCLES = 16; IPv4 frame stalls after 5 payload bytes -> 5 bytes out, then an extra beat tdata = 0, tlast = 1, tuser = 1; drop_cnt += 1; the next frame parses from byte 0.
- Reset asserted after 3 payload bytes of an ARP frame -> all outputs 0 the next cycle, counters 0, and a subsequent frame is processed normally.

Source files
------------

// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_pkg
// Purpose  : Shared L2 constants, receive state encoding and a MAC byte helper
//            for the Ethernet RX demultiplexer.
// Revision : 1.0 - initial release
// ============================================================================
package eth_pkg;

  localparam int          ETH_HDR_LEN  = 14;
  localparam logic [15:0] ETHTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHTYPE_ARP  = 16'h0806;
  localparam logic [47:0] MAC_BCAST    = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    FWD   = 2'd1,
    DROP  = 2'd2,
    ABORT = 2'd3
  } rx_state_e;

  // Byte idx of a MAC address in wire order (idx 0 is the most significant byte).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [3:0] idx);
    logic [47:0] w_sh;
    w_sh = mac << {idx, 3'b000};
    return w_sh[47:40];
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : axis_skid_buf
// Purpose  : Two-entry AXI-Stream register slice with a registered ready.
// Revision : 1.0 - initial release
// ============================================================================
module axis_skid_buf #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             w_load;
  logic             w_in_fire;

  assign w_load    = out_ready || !r_out_valid;
  assign w_in_fire = in_valid && !r_skid_valid;

  // The skid entry only fills when the output register is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (w_load) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_in_fire;
        if (w_in_fire) r_out_data <= in_data;
      end
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= in_data;
    end
  end

  assign in_ready  = !r_skid_valid;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: rtl/eth_rx_demux.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_demux
// Purpose  : Strips the Ethernet header, filters on destination MAC and routes
//            the payload to a per-EtherType output stream.
// Revision : 1.0 - initial release
// ============================================================================
module eth_rx_demux
  import eth_pkg::*;
#(
  parameter int                   NUM_CH         = 2,
  parameter logic [NUM_CH*16-1:0] ETHERTYPES     = {ETHTYPE_IPV4, ETHTYPE_ARP},
  parameter int                   TIMEOUT_CYCLES = 4096,
  parameter int                   CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [47:0]           local_mac,
  input  logic                  promisc,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [NUM_CH*8-1:0]   m_axis_tdata,
  output logic [NUM_CH-1:0]     m_axis_tvalid,
  output logic [NUM_CH-1:0]     m_axis_tlast,
  output logic [NUM_CH-1:0]     m_axis_tuser,
  input  logic [NUM_CH-1:0]     m_axis_tready,
  output logic [CNT_WIDTH-1:0]  fwd_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

  rx_state_e            r_state, w_state_nxt;
  logic [3:0]           r_byte_cnt;
  logic                 r_mac_ok, r_bcast;
  logic [7:0]           r_type_hi;
  logic [SEL_W-1:0]     r_sel, w_sel;
  logic [TMR_W-1:0]     r_timer;
  logic [CNT_WIDTH-1:0] r_fwd_cnt, r_drop_cnt;

  logic                 w_beat, w_in_frame, w_expire, w_last_hdr, w_accept, w_match;
  logic                 w_fwd_inc, w_drop_inc;
  logic [15:0]          w_etype;
  logic [NUM_CH-1:0]    w_skid_valid, w_skid_ready;
  logic [9:0]           w_skid_data;
  logic [NUM_CH*10-1:0] w_out_data;

  assign w_beat     = s_axis_tvalid && s_axis_tready;
  assign w_in_frame = (r_state == FWD) || (r_state == DROP) || (r_state == HDR && r_byte_cnt != 4'd0);
  assign w_expire   = w_in_frame && !s_axis_tvalid && (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign w_last_hdr = (r_byte_cnt == 4'(ETH_HDR_LEN - 1));
  assign w_accept   = r_mac_ok || r_bcast || promisc;
  assign w_etype    = {r_type_hi, s_axis_tdata};

  // Lowest matching table index wins.
  always_comb begin
    w_match = 1'b0;
    w_sel   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ETHERTYPES[16*i +: 16] == w_etype) begin
        w_match = 1'b1;
        w_sel   = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= HDR;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HDR:   if (w_beat && !s_axis_tlast && w_last_hdr)
               w_state_nxt = (w_accept && w_match) ? FWD : DROP;
      FWD:   if (w_beat && s_axis_tlast) w_state_nxt = HDR;
             else if (w_expire)          w_state_nxt = ABORT;
      DROP:  if ((w_beat && s_axis_tlast) || w_expire) w_state_nxt = HDR;
      ABORT: if (w_skid_ready[r_sel]) w_state_nxt = HDR;
      default: w_state_nxt = HDR;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    w_skid_valid  = '0;
    w_skid_data   = {1'b0, s_axis_tlast, s_axis_tdata};
    w_fwd_inc     = 1'b0;
    w_drop_inc    = 1'b0;
    case (r_state)
      HDR, DROP: begin
        s_axis_tready = 1'b1;
        w_drop_inc    = (w_beat && s_axis_tlast) || w_expire;
      end
      FWD: begin
        s_axis_tready       = w_skid_ready[r_sel];
        w_skid_valid[r_sel] = s_axis_tvalid;
        w_fwd_inc           = w_beat && s_axis_tlast;
      end
      ABORT: begin
        w_skid_valid[r_sel] = 1'b1;
        w_skid_data         = 10'b11_0000_0000;
        w_drop_inc          = w_skid_ready[r_sel];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_cnt <= 4'd0;
      r_mac_ok   <= 1'b0;
      r_bcast    <= 1'b0;
      r_type_hi  <= 8'd0;
      r_sel      <= '0;
      r_timer    <= '0;
      r_fwd_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_fwd_inc && !(&r_fwd_cnt))   r_fwd_cnt  <= r_fwd_cnt + CNT_WIDTH'(1);
      if (w_drop_inc && !(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);

      if (w_beat || w_expire || !w_in_frame || w_state_nxt != r_state) r_timer <= '0;
      else if (!s_axis_tvalid)                                          r_timer <= r_timer + TMR_W'(1);

      if (r_state != HDR || w_expire) begin
        r_byte_cnt <= 4'd0;
      end else if (w_beat) begin
        r_byte_cnt <= (s_axis_tlast || w_last_hdr) ? 4'd0 : r_byte_cnt + 4'd1;
        if (r_byte_cnt < 4'd6) begin
          r_mac_ok <= (r_byte_cnt == 4'd0 || r_mac_ok) && (s_axis_tdata == mac_byte(local_mac, r_byte_cnt));
          r_bcast  <= (r_byte_cnt == 4'd0 || r_bcast) && (s_axis_tdata == MAC_BCAST[7:0]);
        end
        if (r_byte_cnt == 4'd12) r_type_hi <= s_axis_tdata;
        if (w_last_hdr)          r_sel     <= w_sel;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) assert (!(w_fwd_inc && w_drop_inc));
  end
`endif

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      axis_skid_buf #(.WIDTH(10)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_data   (w_skid_data),
        .in_valid  (w_skid_valid[g]),
        .in_ready  (w_skid_ready[g]),
        .out_data  (w_out_data[10*g +: 10]),
        .out_valid (m_axis_tvalid[g]),
        .out_ready (m_axis_tready[g])
      );
      assign m_axis_tdata[8*g +: 8] = w_out_data[10*g +: 8];
      assign m_axis_tlast[g]        = w_out_data[10*g + 8];
      assign m_axis_tuser[g]        = w_out_data[10*g + 9];
    end
  endgenerate

  assign fwd_cnt  = r_fwd_cnt;
  assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_rx_demux
// Purpose  : Self-checking bench for eth_rx_demux against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_eth_rx_demux;

  localparam int          NUM_CH = 2;
  localparam int          TMO    = 16;
  localparam logic [31:0] ET_TBL = {16'h0800, 16'h0806};
  localparam logic [47:0] MAC    = 48'h02_11_22_33_44_55;
  localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] OTHER  = 48'h02_99_88_77_66_55;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        promisc = 1'b0;
  logic [7:0]  s_axis_tdata = 8'd0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic [1:0]  m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic [1:0]  m_axis_tready = 2'b11;
  logic [15:0] fwd_cnt, drop_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_fwd = 16'd0;
  logic [15:0] exp_drop = 16'd0;
  logic [10:0] obs_q[$];   // {channel, tuser, tlast, tdata}
  logic [10:0] exp_q[$];
  int          rdy_mode[NUM_CH] = '{0, 0};  // 0: always ready, 1: toggle, 2: random
  int          gap_max = 0;

  eth_rx_demux #(.NUM_CH(NUM_CH), .ETHERTYPES(ET_TBL), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .local_mac(MAC), .promisc(promisc),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      case (rdy_mode[c])
        1:       m_axis_tready[c] = ~m_axis_tready[c];
        2:       m_axis_tready[c] = 1'($urandom_range(0, 1));
        default: m_axis_tready[c] = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++)
        if (m_axis_tvalid[c] && m_axis_tready[c])
          obs_q.push_back({1'(c), m_axis_tuser[c], m_axis_tlast[c], m_axis_tdata[8*c +: 8]});
    end
  end

  function automatic byte_q_t make_frame(input logic [47:0] dst, input logic [15:0] et,
                                         input int plen, input bit seq);
    byte_q_t f;
    for (int i = 0; i < 6; i++) f.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(8'($urandom_range(0, 255)));
    f.push_back(et[15:8]);
    f.push_back(et[7:0]);
    for (int i = 0; i < plen; i++) f.push_back(seq ? 8'(i) : 8'($urandom_range(0, 255)));
    return f;
  endfunction

  // Frame-level reference: decide forward/drop from the header fields, queue expected payload.
  task automatic model_frame(input byte_q_t f, input bit prom);
    logic [47:0] dst;
    logic [15:0] et;
    logic [31:0] tbl;
    int ch;
    tbl = ET_TBL;
    ch  = -1;
    dst = '0;
    if (f.size() <= 14) begin
      exp_drop++;
      return;
    end
    for (int i = 0; i < 6; i++) dst = {dst[39:0], f[i]};
    et = {f[12], f[13]};
    for (int c = NUM_CH - 1; c >= 0; c--) if (tbl[16*c +: 16] == et) ch = c;
    if (ch >= 0 && (dst == MAC || dst == BCAST || prom)) begin
      exp_fwd++;
      for (int j = 14; j < f.size(); j++)
        exp_q.push_back({1'(ch), 1'b0, (j == f.size() - 1), f[j]});
    end else begin
      exp_drop++;
    end
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic l);
    int   n;
    logic rdy;
    n = 0;
    rdy = 1'b0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    do begin
      @(negedge clk);
      rdy = s_axis_tready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 500);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL s_axis_accept: tready stayed 0 for %0d cycles, required a beat", n);
    end
  endtask

  task automatic send_frame(input byte_q_t f);
    for (int i = 0; i < f.size(); i++) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      drive_byte(f[i], (i == f.size() - 1));
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 2000 && obs_q.size() < exp_q.size(); n++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b required 1", s_axis_tready); end
    checks++; if (m_axis_tvalid !== 2'b00) begin errors++; $display("FAIL reset_tvalid: got %b required 00", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 16'h0) begin errors++; $display("FAIL reset_tdata: got %h required 0000", m_axis_tdata); end
    checks++; if ({m_axis_tlast, m_axis_tuser} !== 4'h0) begin errors++; $display("FAIL reset_last_user: got %b required 0000", {m_axis_tlast, m_axis_tuser}); end
    checks++; if (fwd_cnt !== 16'd0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got fwd=%0d drop=%0d required 0/0", fwd_cnt, drop_cnt); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ipv4();
    byte_q_t f;
    f = make_frame(MAC, 16'h0800, 46, 1'b1);
    model_frame(f, 1'b0);
    send_frame(f);
    wait_drain();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ipv4_len: got %0d beats required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ipv4_beat[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (fwd_cnt !== exp_fwd || drop_cnt !== exp_drop) begin errors++; $display("FAIL ipv4_cnt: got %0d/%0d required %0d/%0d", fwd_cnt, drop_cnt, exp_fwd, exp_drop); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_filter();
    byte_q_t f;
    f = make_frame(BCAST, 16'h0806, 28, 1'b0);
    model_frame(f, 1'b0); send_frame(f); wait_drain();
    f = make_frame(MAC, 16'h86DD, 20, 1'b0);
    model_frame(f, 1'b0); send_frame(f); wait_drain();
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL filter_type_drop: got drop=%0d required 1", drop_cnt); end
    f = make_frame(OTHER, 16'h0800, 20, 1'b0);
    model_frame(f, 1'b0); send_frame(f); wait_drain();
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL filter_dst_drop: got drop=%0d required 2", drop_cnt); end
    promisc = 1'b1;
    model_frame(f, 1'b1); send_frame(f); wait_drain();
    promisc = 1'b0;
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL filter_len: got %0d beats required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL filter_beat[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (fwd_cnt !== exp_fwd || drop_cnt !== exp_drop) begin errors++; $display("FAIL filter_cnt: got %0d/%0d required %0d/%0d", fwd_cnt, drop_cnt, exp_fwd, exp_drop); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    byte_q_t f;
    rdy_mode[1] = 1;
    f = make_frame(MAC, 16'h0800, 64, 1'b0);
    model_frame(f, 1'b0); send_frame(f); wait_drain();
    rdy_mode[1] = 0;
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_len: got %0d beats required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (fwd_cnt !== exp_fwd) begin errors++; $display("FAIL bp_cnt: got fwd=%0d required %0d", fwd_cnt, exp_fwd); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_runt();
    byte_q_t f, r;
    f = make_frame(MAC, 16'h0800, 0, 1'b0);
    r = f[0:9];
    model_frame(r, 1'b0); send_frame(r);
    f = make_frame(BCAST, 16'h0806, 28, 1'b0);
    model_frame(f, 1'b0); send_frame(f); wait_drain();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL runt_len: got %0d beats required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL runt_beat[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (fwd_cnt !== exp_fwd || drop_cnt !== exp_drop) begin errors++; $display("FAIL runt_cnt: got %0d/%0d required %0d/%0d", fwd_cnt, drop_cnt, exp_fwd, exp_drop); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    byte_q_t f;
    f = make_frame(MAC, 16'h0800, 5, 1'b0);
    for (int i = 0; i < f.size(); i++) drive_byte(f[i], 1'b0);
    for (int j = 14; j < f.size(); j++) exp_q.push_back({1'b1, 1'b0, 1'b0, f[j]});
    exp_q.push_back({1'b1, 1'b1, 1'b1, 8'h00});
    exp_drop++;
    repeat (3 * TMO) @(posedge clk);
    #1;
    f = make_frame(MAC, 16'h0806, 12, 1'b0);
    model_frame(f, 1'b0); send_frame(f); wait_drain();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL timeout_len: got %0d beats required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL timeout_beat[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (fwd_cnt !== exp_fwd || drop_cnt !== exp_drop) begin errors++; $display("FAIL timeout_cnt: got %0d/%0d required %0d/%0d", fwd_cnt, drop_cnt, exp_fwd, exp_drop); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    byte_q_t f;
    f = make_frame(BCAST, 16'h0806, 3, 1'b0);
    for (int i = 0; i < f.size(); i++) drive_byte(f[i], 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (m_axis_tvalid !== 2'b00 || m_axis_tdata !== 16'h0) begin errors++; $display("FAIL midreset_out: got valid=%b data=%h required 00/0000", m_axis_tvalid, m_axis_tdata); end
    checks++; if ({m_axis_tlast, m_axis_tuser} !== 4'h0) begin errors++; $display("FAIL midreset_last_user: got %b required 0000", {m_axis_tlast, m_axis_tuser}); end
    checks++; if (fwd_cnt !== 16'd0 || drop_cnt !== 16'd0 || s_axis_tready !== 1'b1) begin errors++; $display("FAIL midreset_cnt: got %0d/%0d rdy=%b required 0/0 rdy=1", fwd_cnt, drop_cnt, s_axis_tready); end
    reset = 1'b0;
    @(posedge clk); #1;
    obs_q.delete(); exp_q.delete();
    exp_fwd = 16'd0; exp_drop = 16'd0;
    f = make_frame(MAC, 16'h0800, 20, 1'b0);
    model_frame(f, 1'b0); send_frame(f); wait_drain();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL midreset_len: got %0d beats required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL midreset_beat[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (fwd_cnt !== exp_fwd || drop_cnt !== exp_drop) begin errors++; $display("FAIL midreset_cnt2: got %0d/%0d required %0d/%0d", fwd_cnt, drop_cnt, exp_fwd, exp_drop); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    byte_q_t     f;
    logic [47:0] dst;
    logic [15:0] et;
    bit          prom;
    gap_max = 2;
    rdy_mode[0] = 2;
    rdy_mode[1] = 2;
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 2))
        0:       dst = MAC;
        1:       dst = BCAST;
        default: dst = OTHER;
      endcase
      case ($urandom_range(0, 3))
        0:       et = 16'h0800;
        1:       et = 16'h0806;
        2:       et = 16'h86DD;
        default: et = 16'($urandom_range(0, 65535));
      endcase
      prom    = ($urandom_range(0, 3) == 0);
      promisc = prom;
      f = make_frame(dst, et, $urandom_range(1, 40), 1'b0);
      if ($urandom_range(0, 5) == 0) f = f[0:$urandom_range(0, 13)];
      model_frame(f, prom);
      send_frame(f);
      wait_drain();
    end
    promisc = 1'b0;
    gap_max = 0;
    rdy_mode[0] = 0;
    rdy_mode[1] = 0;
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random_len: got %0d beats required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_beat[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (fwd_cnt !== exp_fwd || drop_cnt !== exp_drop) begin errors++; $display("FAIL random_cnt: got %0d/%0d required %0d/%0d", fwd_cnt, drop_cnt, exp_fwd, exp_drop); end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ipv4();
    test_filter();
    test_backpressure();
    test_runt();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
